dual_phase_accumulator: RTL and testbench
=========================================

// Module: dual_phase_accumulator
//
// PURPOSE
//  Dual-channel NCO phase generator: produces the 32-bit phase words (phase_a/phase_b) consumed by
//  the sine LUT stage and the other waveform generators. Per-channel frequency tuning word (FTW)
//  and phase offset are loaded via a valid/ready config port into shadow registers, then committed
//  atomically on a sample tick so both channels change frequency/phase coherently.
//
// PARAMETERS
//  PHASE_W      32             accumulator/phase/FTW/offset width
//  RST_FTW_A    32'h0000_0000  active and shadow FTW_A after reset
//  RST_FTW_B    32'h0000_0000  active and shadow FTW_B after reset
//
// PORTS
//  clk          in   1        single system clock, all logic posedge
//  rst_n        in   1        asynchronous active-low reset
//  en           in   1        1 = accumulators advance on sample_en; 0 = freeze (config still accepted)
//  sample_en    in   1        one-cycle sample strobe (output sample rate)
//  sync         in   1        pulse: zero both accumulators
//  cfg_valid    in   1        config word valid
//  cfg_ready    out  1        config port ready (high only in IDLE)
//  cfg_sel      in   3        0=FTW_A 1=FTW_B 2=POFF_A 3=POFF_B 4=COMMIT 5-7=ignored
//  cfg_data     in   PHASE_W  write data; for COMMIT bit0=1 also zeroes accumulators at apply
//  phase_a      out  PHASE_W  acc_a + poff_a, registered
//  phase_b      out  PHASE_W  acc_b + poff_b, registered
//  phase_valid  out  1        one-cycle pulse: phase_a/b updated this cycle
//  wrap_a       out  1        one-cycle pulse, coincident with phase_valid, acc_a carried out
//  wrap_b       out  1        same for acc_b
//  commit_done  out  1        one-cycle pulse on the tick that applied a commit
//
// BEHAVIOUR
//  - Reset: acc_a/b=0; poff active/shadow=0; FTW active/shadow=RST_FTW_x; phase_a/b=0;
//    phase_valid=wrap_a/b=commit_done=0; FSM=IDLE, so cfg_ready=1.
//  - Handshake: transfer when cfg_valid&&cfg_ready. Sel 0-3 write the shadow reg only. Sel 5-7 are
//    accepted and discarded. Sel 4 (COMMIT) latches clr=cfg_data[0] and moves the FSM to PENDING.
//  - FSM
//    - IDLE: cfg_ready=1; COMMIT accepted -> PENDING.
//    - PENDING: cfg_ready=0; waits for tick = sample_en && en. On tick: active <= shadow (all 4 regs)
//      and commit_done=1 -> IDLE. cfg_ready=1 the cycle after the apply edge.
//  - Tick arithmetic, modulo 2^PHASE_W, using FTW/poff values in effect for this tick (new values
//    if a commit applies on it):
//    - acc_nxt = acc + ftw, or = 0 if commit with clr applies on this tick.
//    - acc <= acc_nxt; phase <= acc_nxt + poff; wrap = carry-out of acc + ftw (0 when clr);
//      phase_valid=1 on the cycle after the tick edge (registered, 1-cycle latency).
//  - No tick (en=0 or sample_en=0): acc and phase hold; phase_valid=wrap=0.
//  - sync=1: acc_a/b <= 0 and phase_x <= active poff_x; phase_valid=1, wrap=0. Overrides a
//    coincident tick advance. A PENDING commit still applies on that tick (registers update,
//    commit_done=1), but acc is still forced to 0.
//  - en=0 while PENDING: commit waits indefinitely. cfg_ready stays 0.
//  - Shadow writes never alter outputs until a commit applies. Repeated writes before COMMIT: last wins.
//  - rst_n assertion mid-PENDING: commit is discarded, all state returns to reset values immediately.
//
// TESTING
//  1 Reset: hold rst_n=0 -> phase_a/b=0, cfg_ready=1, phase_valid=0; release, no config -> FTW=RST_FTW.
//  2 FTW_A=32'h4000_0000, COMMIT(0), 5 ticks -> phase_a 0x40000000,0x80000000,0xC0000000,0x0,0x40000000;
//    wrap_a=1 only on 4th.
//  3 POFF_B=32'h8000_0000, FTW_B=1, COMMIT(1) -> apply tick: phase_b=0x80000000, commit_done=1;
//    next tick phase_b=0x80000001.
//  4 COMMIT with sample_en=0 for 10 cycles -> cfg_ready=0 for the whole wait, outputs frozen;
//    first tick applies; cfg_ready=1 next cycle.
//  5 en=0 with 3 sample_en pulses -> phase_a/b unchanged, no phase_valid; shadow write accepted.
//  6 sync coincident with tick at FTW_A=0x100, poff=0 -> phase_a=0, wrap_a=0; next tick phase_a=0x100.

Source files
------------

// File: rtl/dual_phase_accumulator_if.sv
// Config and phase-output bundle for the dual-channel NCO phase generator.
// master: the config source / phase consumer (drives en, strobes, cfg_*).
// slave:  the accumulator itself (drives cfg_ready and all phase outputs).
// PHASE_W must match the PHASE_W of the attached dual_phase_accumulator.
interface dual_phase_accumulator_if #(
  parameter int PHASE_W = 32
);
  logic               en;
  logic               sample_en;
  logic               sync;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [2:0]         cfg_sel;
  logic [PHASE_W-1:0] cfg_data;
  logic [PHASE_W-1:0] phase_a;
  logic [PHASE_W-1:0] phase_b;
  logic               phase_valid;
  logic               wrap_a;
  logic               wrap_b;
  logic               commit_done;

  modport master (
    output en, sample_en, sync, cfg_valid, cfg_sel, cfg_data,
    input  cfg_ready, phase_a, phase_b, phase_valid, wrap_a, wrap_b, commit_done
  );

  modport slave (
    input  en, sample_en, sync, cfg_valid, cfg_sel, cfg_data,
    output cfg_ready, phase_a, phase_b, phase_valid, wrap_a, wrap_b, commit_done
  );
endinterface

// File: rtl/dual_phase_accumulator.sv
// Dual-channel NCO phase accumulator with shadowed FTW/offset committed atomically on a sample tick.
// Latency: phase/wrap/commit_done registered, valid one cycle after the tick (or sync) edge.
// Backpressure: cfg_ready drops while a commit waits for its tick; phase outputs are never stalled.
// Ports: clk, rst_n (async, active-low); bus (slave modport): en, sample_en, sync, cfg_valid/ready,
//   cfg_sel (0=FTW_A 1=FTW_B 2=POFF_A 3=POFF_B 4=COMMIT, 5-7 dropped), cfg_data,
//   phase_a/b, phase_valid, wrap_a/b, commit_done.
module dual_phase_accumulator #(
  parameter int                 PHASE_W   = 32,
  parameter logic [PHASE_W-1:0] RST_FTW_A = '0,
  parameter logic [PHASE_W-1:0] RST_FTW_B = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dual_phase_accumulator_if.slave bus
);

  typedef enum logic {IDLE, PENDING} state_e;
  typedef logic [PHASE_W-1:0] word_t;

  localparam logic [2:0] SEL_FTW_A  = 3'd0;
  localparam logic [2:0] SEL_FTW_B  = 3'd1;
  localparam logic [2:0] SEL_POFF_A = 3'd2;
  localparam logic [2:0] SEL_POFF_B = 3'd3;
  localparam logic [2:0] SEL_COMMIT = 3'd4;

  state_e state_q, state_d;
  word_t  acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  word_t  ftw_a_q, ftw_a_d, ftw_b_q, ftw_b_d;
  word_t  poff_a_q, poff_a_d, poff_b_q, poff_b_d;
  word_t  sh_ftw_a_q, sh_ftw_a_d, sh_ftw_b_q, sh_ftw_b_d;
  word_t  sh_poff_a_q, sh_poff_a_d, sh_poff_b_q, sh_poff_b_d;
  word_t  phase_a_q, phase_a_d, phase_b_q, phase_b_d;
  logic   clr_q, clr_d;
  logic   phase_valid_q, phase_valid_d;
  logic   wrap_a_q, wrap_a_d, wrap_b_q, wrap_b_d;
  logic   commit_done_q, commit_done_d;

  logic               cfg_fire, tick, apply;
  word_t              ftw_a_eff, ftw_b_eff, poff_a_eff, poff_b_eff;
  logic [PHASE_W:0]   sum_a, sum_b;

  always_comb begin
    state_d       = state_q;
    acc_a_d       = acc_a_q;
    acc_b_d       = acc_b_q;
    ftw_a_d       = ftw_a_q;
    ftw_b_d       = ftw_b_q;
    poff_a_d      = poff_a_q;
    poff_b_d      = poff_b_q;
    sh_ftw_a_d    = sh_ftw_a_q;
    sh_ftw_b_d    = sh_ftw_b_q;
    sh_poff_a_d   = sh_poff_a_q;
    sh_poff_b_d   = sh_poff_b_q;
    phase_a_d     = phase_a_q;
    phase_b_d     = phase_b_q;
    clr_d         = clr_q;
    phase_valid_d = 1'b0;
    wrap_a_d      = 1'b0;
    wrap_b_d      = 1'b0;
    commit_done_d = 1'b0;

    cfg_fire = bus.cfg_valid && (state_q == IDLE);
    tick     = bus.sample_en && bus.en;
    apply    = (state_q == PENDING) && tick;

    // Config port only accepts in IDLE, so shadow writes and a commit apply never collide.
    if (cfg_fire) begin
      case (bus.cfg_sel)
        SEL_FTW_A:  sh_ftw_a_d  = bus.cfg_data;
        SEL_FTW_B:  sh_ftw_b_d  = bus.cfg_data;
        SEL_POFF_A: sh_poff_a_d = bus.cfg_data;
        SEL_POFF_B: sh_poff_b_d = bus.cfg_data;
        SEL_COMMIT: begin
          state_d = PENDING;
          clr_d   = bus.cfg_data[0];
        end
        default: ;
      endcase
    end

    if (apply) begin
      ftw_a_d       = sh_ftw_a_q;
      ftw_b_d       = sh_ftw_b_q;
      poff_a_d      = sh_poff_a_q;
      poff_b_d      = sh_poff_b_q;
      state_d       = IDLE;
      commit_done_d = 1'b1;
    end

    // The tick that applies a commit already runs on the new tuning values.
    ftw_a_eff  = apply ? sh_ftw_a_q  : ftw_a_q;
    ftw_b_eff  = apply ? sh_ftw_b_q  : ftw_b_q;
    poff_a_eff = apply ? sh_poff_a_q : poff_a_q;
    poff_b_eff = apply ? sh_poff_b_q : poff_b_q;
    sum_a      = {1'b0, acc_a_q} + {1'b0, ftw_a_eff};
    sum_b      = {1'b0, acc_b_q} + {1'b0, ftw_b_eff};

    if (bus.sync) begin
      // sync wins over a coincident advance; a commit on the same tick still lands above.
      acc_a_d       = '0;
      acc_b_d       = '0;
      phase_a_d     = poff_a_eff;
      phase_b_d     = poff_b_eff;
      phase_valid_d = 1'b1;
    end else if (tick) begin
      if (apply && clr_q) begin
        acc_a_d = '0;
        acc_b_d = '0;
      end else begin
        acc_a_d  = sum_a[PHASE_W-1:0];
        acc_b_d  = sum_b[PHASE_W-1:0];
        wrap_a_d = sum_a[PHASE_W];
        wrap_b_d = sum_b[PHASE_W];
      end
      phase_a_d     = acc_a_d + poff_a_eff;
      phase_b_d     = acc_b_d + poff_b_eff;
      phase_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_a_q       <= '0;
      acc_b_q       <= '0;
      ftw_a_q       <= RST_FTW_A;
      ftw_b_q       <= RST_FTW_B;
      poff_a_q      <= '0;
      poff_b_q      <= '0;
      sh_ftw_a_q    <= RST_FTW_A;
      sh_ftw_b_q    <= RST_FTW_B;
      sh_poff_a_q   <= '0;
      sh_poff_b_q   <= '0;
      phase_a_q     <= '0;
      phase_b_q     <= '0;
      clr_q         <= 1'b0;
      phase_valid_q <= 1'b0;
      wrap_a_q      <= 1'b0;
      wrap_b_q      <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_a_q       <= acc_a_d;
      acc_b_q       <= acc_b_d;
      ftw_a_q       <= ftw_a_d;
      ftw_b_q       <= ftw_b_d;
      poff_a_q      <= poff_a_d;
      poff_b_q      <= poff_b_d;
      sh_ftw_a_q    <= sh_ftw_a_d;
      sh_ftw_b_q    <= sh_ftw_b_d;
      sh_poff_a_q   <= sh_poff_a_d;
      sh_poff_b_q   <= sh_poff_b_d;
      phase_a_q     <= phase_a_d;
      phase_b_q     <= phase_b_d;
      clr_q         <= clr_d;
      phase_valid_q <= phase_valid_d;
      wrap_a_q      <= wrap_a_d;
      wrap_b_q      <= wrap_b_d;
      commit_done_q <= commit_done_d;
    end
  end

  assign bus.cfg_ready   = (state_q == IDLE);
  assign bus.phase_a     = phase_a_q;
  assign bus.phase_b     = phase_b_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.wrap_a      = wrap_a_q;
  assign bus.wrap_b      = wrap_b_q;
  assign bus.commit_done = commit_done_q;

endmodule

// File: tb/tb_dual_phase_accumulator.sv
// Self-checking bench for dual_phase_accumulator: directed scenarios with inline checks plus a
// scoreboard (expected phase words queued at drive time, popped on every phase_valid).
module tb_dual_phase_accumulator;
  localparam int W = 32;
  localparam logic [W-1:0] RFA = 32'h0000_0010;
  localparam logic [W-1:0] RFB = 32'h0000_0003;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dual_phase_accumulator_if #(.PHASE_W(W)) bus ();

  dual_phase_accumulator #(.PHASE_W(W), .RST_FTW_A(RFA), .RST_FTW_B(RFB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    logic         wa;
    logic         wb;
    logic         cd;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // reference model state
  logic [W-1:0] m_acc_a, m_acc_b, m_ftw_a, m_ftw_b, m_poff_a, m_poff_b;
  logic [W-1:0] s_ftw_a, s_ftw_b, s_poff_a, s_poff_b;
  logic [W-1:0] m_last_pa, m_last_pb;
  bit           m_pend, m_clr;

  task automatic model_reset();
    m_acc_a = '0; m_acc_b = '0;
    m_ftw_a = RFA; m_ftw_b = RFB; s_ftw_a = RFA; s_ftw_b = RFB;
    m_poff_a = '0; m_poff_b = '0; s_poff_a = '0; s_poff_b = '0;
    m_last_pa = '0; m_last_pb = '0;
    m_pend = 1'b0; m_clr = 1'b0;
    sb.delete();
  endtask

  // One clock of sample_en/sync stimulus; queues the expected output if one is due.
  task automatic cycle(input bit se, input bit sy);
    bit         tick, apply;
    exp_t       e;
    logic [W:0] s;
    bus.sample_en = se;
    bus.sync      = sy;
    tick  = se && (bus.en === 1'b1);
    apply = m_pend && tick;
    if (apply) begin
      m_ftw_a = s_ftw_a; m_ftw_b = s_ftw_b; m_poff_a = s_poff_a; m_poff_b = s_poff_b;
      m_pend = 1'b0;
    end
    e = '0;
    e.cd = apply;
    if (sy) begin
      m_acc_a = '0; m_acc_b = '0;
      e.pa = m_poff_a; e.pb = m_poff_b;
    end else if (tick) begin
      if (apply && m_clr) begin
        m_acc_a = '0; m_acc_b = '0;
      end else begin
        s = {1'b0, m_acc_a} + {1'b0, m_ftw_a}; m_acc_a = s[W-1:0]; e.wa = s[W];
        s = {1'b0, m_acc_b} + {1'b0, m_ftw_b}; m_acc_b = s[W-1:0]; e.wb = s[W];
      end
      e.pa = m_acc_a + m_poff_a;
      e.pb = m_acc_b + m_poff_b;
    end
    if (sy || tick) begin
      sb.push_back(e);
      m_last_pa = e.pa; m_last_pb = e.pb;
    end
    @(negedge clk);
    bus.sample_en = 1'b0;
    bus.sync      = 1'b0;
  endtask

  // Config write with no ticks; a port that never becomes ready counts as a failure.
  task automatic cfg_write(input logic [2:0] sel, input logic [W-1:0] data);
    int n = 0;
    bus.sample_en = 1'b0; bus.sync = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_sel = sel; bus.cfg_data = data;
    while (bus.cfg_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.cfg_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL cfg_timeout: sel=%0d cfg_ready=%b, required 1 within 20 cycles", sel, bus.cfg_ready);
    end else begin
      @(negedge clk);
      case (sel)
        3'd0: s_ftw_a  = data;
        3'd1: s_ftw_b  = data;
        3'd2: s_poff_a = data;
        3'd3: s_poff_b = data;
        3'd4: begin m_pend = 1'b1; m_clr = data[0]; end
        default: ;
      endcase
    end
    bus.cfg_valid = 1'b0;
  endtask

  // Scoreboard monitor
  exp_t mon_got, mon_exp;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon_got = {bus.phase_a, bus.phase_b, bus.wrap_a, bus.wrap_b, bus.commit_done};
      if (bus.phase_valid === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: phase_valid=1 with nothing expected, pa=%h pb=%h", bus.phase_a, bus.phase_b);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_got !== mon_exp) begin
            miscompares++;
            $display("FAIL sb_output: got pa=%h pb=%h wa=%b wb=%b cd=%b, want pa=%h pb=%h wa=%b wb=%b cd=%b",
                     mon_got.pa, mon_got.pb, mon_got.wa, mon_got.wb, mon_got.cd,
                     mon_exp.pa, mon_exp.pb, mon_exp.wa, mon_exp.wb, mon_exp.cd);
          end
        end
      end else if (bus.phase_valid !== 1'b0 || bus.wrap_a !== 1'b0 || bus.wrap_b !== 1'b0 ||
                   bus.commit_done !== 1'b0) begin
        vectors++; miscompares++;
        $display("FAIL sb_stray_pulse: valid=%b wa=%b wb=%b cd=%b, want all 0",
                 bus.phase_valid, bus.wrap_a, bus.wrap_b, bus.commit_done);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.phase_a !== '0) begin miscompares++; $display("FAIL reset_phase_a: got %h want 0", bus.phase_a); end
    vectors++; if (bus.phase_b !== '0) begin miscompares++; $display("FAIL reset_phase_b: got %h want 0", bus.phase_b); end
    vectors++; if (bus.cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cfg_ready: got %b want 1", bus.cfg_ready); end
    vectors++; if (bus.phase_valid !== 1'b0 || bus.commit_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_pulses: valid=%b cd=%b want 0 0", bus.phase_valid, bus.commit_done);
    end
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0);
    vectors++; if (bus.phase_a !== RFA) begin miscompares++; $display("FAIL reset_ftw_a: got %h want %h", bus.phase_a, RFA); end
    vectors++; if (bus.phase_b !== RFB) begin miscompares++; $display("FAIL reset_ftw_b: got %h want %h", bus.phase_b, RFB); end
  endtask

  task automatic test_ftw_a();
    logic [W-1:0] exp_pa [5] = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000, 32'h4000_0000};
    logic         exp_wa [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    cycle(1'b0, 1'b1);
    cfg_write(3'd0, 32'h4000_0000);
    cfg_write(3'd4, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0);
      vectors++; if (bus.phase_a !== exp_pa[i] || bus.wrap_a !== exp_wa[i]) begin
        miscompares++;
        $display("FAIL ftw_a_tick%0d: got pa=%h wa=%b want pa=%h wa=%b", i, bus.phase_a, bus.wrap_a, exp_pa[i], exp_wa[i]);
      end
    end
  endtask

  task automatic test_poff_b();
    cfg_write(3'd3, 32'h8000_0000);
    cfg_write(3'd1, 32'h1);
    cfg_write(3'd4, 32'h1);
    cycle(1'b1, 1'b0);
    vectors++; if (bus.phase_b !== 32'h8000_0000 || bus.commit_done !== 1'b1) begin
      miscompares++; $display("FAIL poff_b_apply: got pb=%h cd=%b want 80000000 1", bus.phase_b, bus.commit_done);
    end
    cycle(1'b1, 1'b0);
    vectors++; if (bus.phase_b !== 32'h8000_0001 || bus.commit_done !== 1'b0) begin
      miscompares++; $display("FAIL poff_b_next: got pb=%h cd=%b want 80000001 0", bus.phase_b, bus.commit_done);
    end
  endtask

  task automatic test_commit_wait();
    int bad = 0;
    cfg_write(3'd0, 32'h0000_1000);
    cfg_write(3'd4, 32'h0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0);
      if (bus.cfg_ready !== 1'b0 || bus.phase_valid !== 1'b0 || bus.phase_a !== m_last_pa) bad++;
    end
    vectors++; if (bad != 0) begin
      miscompares++; $display("FAIL commit_wait_hold: %0d bad cycles of 10, want 0 (ready=0, outputs frozen)", bad);
    end
    cycle(1'b1, 1'b0);
    vectors++; if (bus.commit_done !== 1'b1 || bus.cfg_ready !== 1'b1) begin
      miscompares++; $display("FAIL commit_wait_apply: cd=%b ready=%b want 1 1", bus.commit_done, bus.cfg_ready);
    end
  endtask

  task automatic test_en_freeze();
    int bad = 0;
    bus.en = 1'b0;
    repeat (3) begin
      cycle(1'b1, 1'b0);
      if (bus.phase_valid !== 1'b0 || bus.phase_a !== m_last_pa || bus.phase_b !== m_last_pb) bad++;
    end
    vectors++; if (bad != 0) begin
      miscompares++; $display("FAIL en_freeze_hold: %0d bad cycles of 3, want 0", bad);
    end
    cfg_write(3'd1, 32'h0000_0005);
    cfg_write(3'd4, 32'h0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    vectors++; if (bus.cfg_ready !== 1'b0 || bus.commit_done !== 1'b0) begin
      miscompares++; $display("FAIL en_freeze_pending: ready=%b cd=%b want 0 0", bus.cfg_ready, bus.commit_done);
    end
    bus.en = 1'b1;
    cycle(1'b1, 1'b0);
    vectors++; if (bus.commit_done !== 1'b1) begin
      miscompares++; $display("FAIL en_freeze_release: cd=%b want 1", bus.commit_done);
    end
  endtask

  task automatic test_sync();
    cfg_write(3'd0, 32'h0000_0100);
    cfg_write(3'd2, 32'h0);
    cfg_write(3'd4, 32'h1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    vectors++; if (bus.phase_a !== 32'h0 || bus.wrap_a !== 1'b0 || bus.phase_valid !== 1'b1) begin
      miscompares++; $display("FAIL sync_tick: pa=%h wa=%b valid=%b want 0 0 1", bus.phase_a, bus.wrap_a, bus.phase_valid);
    end
    cycle(1'b1, 1'b0);
    vectors++; if (bus.phase_a !== 32'h0000_0100) begin
      miscompares++; $display("FAIL sync_next: pa=%h want 00000100", bus.phase_a);
    end
  endtask

  task automatic test_shadow_rules();
    cfg_write(3'd0, 32'h0000_0111);
    cfg_write(3'd0, 32'h0000_0020);
    cfg_write(3'd5, 32'hFFFF_FFFF);
    cfg_write(3'd6, 32'hFFFF_FFFF);
    cfg_write(3'd7, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b1);
    vectors++; if (bus.phase_a !== 32'h0) begin
      miscompares++; $display("FAIL shadow_isolated: pa=%h want 0", bus.phase_a);
    end
    cfg_write(3'd4, 32'h0);
    cycle(1'b1, 1'b0);
    vectors++; if (bus.phase_a !== 32'h0000_0020) begin
      miscompares++; $display("FAIL shadow_last_wins: pa=%h want 00000020", bus.phase_a);
    end
  endtask

  task automatic test_reset_pending();
    cfg_write(3'd0, 32'h0000_0999);
    cfg_write(3'd4, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.cfg_ready !== 1'b1 || bus.phase_a !== '0) begin
      miscompares++; $display("FAIL reset_pending_async: ready=%b pa=%h want 1 0", bus.cfg_ready, bus.phase_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0);
    vectors++; if (bus.phase_a !== RFA || bus.commit_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_pending_discard: pa=%h cd=%b want %h 0", bus.phase_a, bus.commit_done, RFA);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0) bus.en = ~bus.en;
      if (r < 4 && !m_pend) cfg_write(3'($urandom_range(0, 7)), $urandom);
      else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end
    bus.en = 1'b1;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b1; bus.sample_en = 1'b0; bus.sync = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_sel = 3'd0; bus.cfg_data = '0;
    model_reset();
    test_reset();
    test_ftw_a();
    test_poff_b();
    test_commit_wait();
    test_en_freeze();
    test_sync();
    test_shadow_rules();
    test_reset_pending();
    test_back_to_back();
    @(negedge clk);
    vectors++; if (sb.size() != 0) begin
      miscompares++; $display("FAIL sb_drain: %0d expected outputs never seen, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
